// File: rtl/fifo_access_pkg.sv
// Shared types and constants for the FIFO access controller.
package fifo_access_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam int DEPTH_DEF = 8;
    localparam int STALL_W   = 16;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rr_arbiter
    import fifo_access_pkg::*;
#(
    parameter int NUM_REQ = 2
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int PTR_W = (clog2(NUM_REQ) < 1) ? 1 : clog2(NUM_REQ);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt       = '0;
        w_ptr_nxt = r_ptr;
        w_idx     = '0;
        w_found   = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = PTR_W'((int'(r_ptr) + off) % NUM_REQ);
            if (enable && !w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                w_ptr_nxt  = PTR_W'((int'(r_ptr) + off + 1) % NUM_REQ);
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|gnt) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Write-port arbiter, read gate, occupancy tracker and flush drain in front of the 8x8 FIFO.
// Optional stall statistics counter enabled by defining FIFO_ACCESS_STATS_EN.
module fifo_access_ctrl
    import fifo_access_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    parameter  int DATA_W  = 8,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int CNT_W   = clog2(DEPTH + 1)
)
(
`ifdef FIFO_ACCESS_STATS_EN
    input  logic                      stat_clr,
    output logic [STALL_W-1:0]        stall_cnt,
`endif
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_gnt,
    input  logic                      rd_req,
    output logic                      rd_gnt,
    output logic                      rd_valid,
    input  logic                      flush,
    output logic                      busy,
    output logic                      fifo_wr,
    output logic                      fifo_rd,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_rd_valid;
    logic             w_run;
    logic             w_drain;
    logic             w_wr_en;

    // Strobes are qualified with rst_n so the FIFO sees nothing while reset is held.
    assign w_run   = rst_n && (r_state == RUN);
    assign w_drain = rst_n && (r_state == DRAIN);
    assign w_wr_en = w_run && !full;

    assign full     = (r_count == CNT_MAX);
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign busy     = (r_state == DRAIN);
    assign rd_valid = r_rd_valid;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (wr_req),
        .enable (w_wr_en),
        .gnt    (wr_gnt)
    );

    assign fifo_wr = |wr_gnt;
    assign rd_gnt  = w_run && rd_req && !empty;
    assign fifo_rd = rd_gnt || (w_drain && !empty);

    always_comb begin
        fifo_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_gnt[i]) fifo_din = wr_data[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        w_count_nxt = r_count;
        if (fifo_wr && !fifo_rd) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!fifo_wr && fifo_rd) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Drain ends once the last real read has been issued, so RUN resumes with count already 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (flush) w_state_nxt = DRAIN;
            DRAIN:   if (w_count_nxt == '0) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= rd_gnt;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(full && fifo_wr && !fifo_rd));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(empty && fifo_rd && !fifo_wr));

`ifdef FIFO_ACCESS_STATS_EN
    logic [STALL_W-1:0] r_stall_cnt;
    logic               w_stall;

    assign w_stall   = (|wr_req) && !fifo_wr && (full || (r_state == DRAIN));
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stat_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Self-checking bench for fifo_access_ctrl: vector table plus hand-written reset and flush sequences.
module tb_fifo_access_ctrl;

    localparam int NUM_REQ = 2;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        wr_req;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic [NUM_REQ-1:0]        wr_gnt;
    logic                      rd_req;
    logic                      rd_gnt;
    logic                      rd_valid;
    logic                      flush;
    logic                      busy;
    logic                      fifo_wr;
    logic                      fifo_rd;
    logic [DATA_W-1:0]         fifo_din;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      empty;
`ifdef FIFO_ACCESS_STATS_EN
    logic                      stat_clr = 1'b0;
    logic [15:0]               stall_cnt;
`endif

    fifo_access_ctrl #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(8)) dut (
`ifdef FIFO_ACCESS_STATS_EN
        .stat_clr  (stat_clr),
        .stall_cnt (stall_cnt),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .flush     (flush),
        .busy      (busy),
        .fifo_wr   (fifo_wr),
        .fifo_rd   (fifo_rd),
        .fifo_din  (fifo_din),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_wr_q[$];

    typedef struct {
        logic [1:0] wr_req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       rd_req;
        logic [1:0] exp_gnt;
        logic       exp_rd;
        int         exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [1:0] wr, input logic [7:0] d0, input logic [7:0] d1,
                           input logic rd, input logic [1:0] gnt, input logic exp_rd, input int cnt);
        vec_t v;
        v.wr_req = wr; v.d0 = d0; v.d1 = d1; v.rd_req = rd;
        v.exp_gnt = gnt; v.exp_rd = exp_rd; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [1:0] wr, input logic [7:0] d0, input logic [7:0] d1,
                         input logic rd, input logic fl);
        wr_req  = wr;
        wr_data = {d1, d0};
        rd_req  = rd;
        flush   = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Write scoreboard: each observed FIFO write must match the oldest expected datum.
    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            check("wr_scoreboard_has_entry", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) check("fifo_din", 32'(fifo_din), 32'(exp_wr_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt_model;
        logic prev_rd;

        // Vector table, starting from reset: pointer 0, count 0.
        for (int i = 0; i < 8; i++)
            add_vec(2'b11, 8'hA0, 8'hB1, 1'b0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b0, i + 1);
        add_vec(2'b11, 8'hA0, 8'hB1, 1'b0, 2'b00, 1'b0, 8);
        add_vec(2'b11, 8'hA0, 8'hB1, 1'b1, 2'b00, 1'b1, 7);
        add_vec(2'b11, 8'hA0, 8'hB1, 1'b1, 2'b01, 1'b1, 7);
        for (int i = 0; i < 7; i++)
            add_vec(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b1, 6 - i);
        add_vec(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 0);
        add_vec(2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 0);
        add_vec(2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 1'b0, 0);
        for (int i = 0; i < 8; i++)
            add_vec(2'b01, 8'(8'h10 + i), 8'hEE, 1'b0, 2'b01, 1'b0, i + 1);
        add_vec(2'b01, 8'h18, 8'hEE, 1'b0, 2'b00, 1'b0, 8);
        add_vec(2'b01, 8'h18, 8'hEE, 1'b0, 2'b00, 1'b0, 8);

        // Reset, then asynchronous reset in the middle of traffic.
        rst_n = 1'b0;
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        next_cycle();
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        rst_n = 1'b1;

        drive(2'b01, 8'h55, 8'h00, 1'b0, 1'b0);
        exp_wr_q.push_back(8'h55);
        next_cycle();
        drive(2'b01, 8'h66, 8'h00, 1'b1, 1'b0);
        exp_wr_q.push_back(8'h66);
        #1;
        check("pre_rst_rd_gnt", 32'(rd_gnt), 32'd1);
        next_cycle();
        drive(2'b01, 8'h77, 8'h00, 1'b1, 1'b0);
        #1;
        check("pre_rst_wr_gnt", 32'(wr_gnt), 32'd1);
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        check("pre_rst_count", 32'(count), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_wr_gnt", 32'(wr_gnt), 32'd0);
        check("async_rst_rd_gnt", 32'(rd_gnt), 32'd0);
        check("async_rst_fifo_wr", 32'(fifo_wr), 32'd0);
        check("async_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("async_rst_fifo_din", 32'(fifo_din), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_rd_valid", 32'(rd_valid), 32'd0);
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Table: round-robin, full blocking, simultaneous ops, empty reads, single-requester fill.
        cnt_model = 0;
        prev_rd   = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].wr_req, vecs[i].d0, vecs[i].d1, vecs[i].rd_req, 1'b0);
            if (vecs[i].exp_gnt[0]) exp_wr_q.push_back(vecs[i].d0);
            else if (vecs[i].exp_gnt[1]) exp_wr_q.push_back(vecs[i].d1);
            @(negedge clk);
            check($sformatf("v%0d wr_gnt", i), 32'(wr_gnt), 32'(vecs[i].exp_gnt));
            check($sformatf("v%0d fifo_wr", i), 32'(fifo_wr), 32'(|vecs[i].exp_gnt));
            check($sformatf("v%0d rd_gnt", i), 32'(rd_gnt), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d fifo_rd", i), 32'(fifo_rd), 32'(vecs[i].exp_rd));
            check($sformatf("v%0d count", i), 32'(count), 32'(cnt_model));
            check($sformatf("v%0d full", i), 32'(full), 32'(cnt_model == 8));
            check($sformatf("v%0d empty", i), 32'(empty), 32'(cnt_model == 0));
            check($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(prev_rd));
            check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
            next_cycle();
            prev_rd   = vecs[i].exp_rd;
            cnt_model = vecs[i].exp_cnt;
        end
        check("table_end_count", 32'(count), 32'(cnt_model));

        // Read down from 8 to 5.
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 8'h00, 8'h00, 1'b1, 1'b0);
            @(negedge clk);
            check("pre_flush_rd_gnt", 32'(rd_gnt), 32'd1);
            next_cycle();
        end

        // Flush from count 5: five drain reads, no grants, no rd_valid, then RUN.
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        check("flush_cycle_busy", 32'(busy), 32'd0);
        check("flush_cycle_count", 32'(count), 32'd5);
        check("flush_cycle_rd_valid", 32'(rd_valid), 32'd1);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            drive(2'b11, 8'h33, 8'h44, 1'b1, c == 2);
            @(negedge clk);
            check($sformatf("drain%0d busy", c), 32'(busy), 32'd1);
            check($sformatf("drain%0d fifo_rd", c), 32'(fifo_rd), 32'd1);
            check($sformatf("drain%0d wr_gnt", c), 32'(wr_gnt), 32'd0);
            check($sformatf("drain%0d rd_gnt", c), 32'(rd_gnt), 32'd0);
            check($sformatf("drain%0d fifo_wr", c), 32'(fifo_wr), 32'd0);
            check($sformatf("drain%0d rd_valid", c), 32'(rd_valid), 32'd0);
            check($sformatf("drain%0d count", c), 32'(count), 32'(5 - c));
            next_cycle();
        end
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("post_drain_busy", 32'(busy), 32'd0);
        check("post_drain_count", 32'(count), 32'd0);
        check("post_drain_empty", 32'(empty), 32'd1);
        check("post_drain_fifo_rd", 32'(fifo_rd), 32'd0);
        check("post_drain_rd_valid", 32'(rd_valid), 32'd0);
        next_cycle();

        // Flush when already empty: one DRAIN cycle with no reads.
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
        next_cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("empty_flush_busy", 32'(busy), 32'd1);
        check("empty_flush_fifo_rd", 32'(fifo_rd), 32'd0);
        next_cycle();
        @(negedge clk);
        check("empty_flush_return", 32'(busy), 32'd0);
        next_cycle();

        // Requester 1 alone, then a write in the flush cycle, then reset mid-drain.
        for (int i = 0; i < 2; i++) begin
            drive(2'b10, 8'h00, 8'hC0, 1'b0, 1'b0);
            exp_wr_q.push_back(8'hC0);
            @(negedge clk);
            check("req1_wr_gnt", 32'(wr_gnt), 32'd2);
            next_cycle();
        end
        drive(2'b01, 8'h99, 8'h00, 1'b0, 1'b1);
        exp_wr_q.push_back(8'h99);
        @(negedge clk);
        check("flush_cycle_wr_gnt", 32'(wr_gnt), 32'd1);
        next_cycle();
        drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("drain2_busy", 32'(busy), 32'd1);
        check("drain2_count", 32'(count), 32'd3);
        next_cycle();
        #1;
        rst_n = 1'b0;
        #1;
        check("drain_rst_busy", 32'(busy), 32'd0);
        check("drain_rst_count", 32'(count), 32'd0);
        check("drain_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        check("after_rst_busy", 32'(busy), 32'd0);
        check("after_rst_count", 32'(count), 32'd0);

        check("wr_scoreboard_drained", 32'(exp_wr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
- Access controller for the 8-deep x 8-bit FIFO. Shares the single write port among NUM_REQ producers using round-robin arbitration, and services one consumer's read requests.
- Tracks occupancy internally, because the FIFO top level does not export full/empty. No write is ever issued when full; no read is ever issued when empty.
- Provides a flush sequence that drains the FIFO with real reads. This keeps the FIFO's internal pointers consistent.
- Sits directly in front of the FIFO top level and drives its write_signal, read_signal and data_in.

Parameters:
- NUM_REQ, 2, number of write requesters (2..4).
- DATA_W, 8, data width.
- DEPTH, 8, FIFO entries; must match the FIFO address range.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_req  in  NUM_REQ  per-requester write request; level, held until granted.
- wr_data  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- wr_gnt  out  NUM_REQ  one-hot; requester's data is written this cycle.
- rd_req  in  1  consumer read request.
- rd_gnt  out  1  read issued to the FIFO this cycle.
- rd_valid  out  1  consumer should sample FIFO data_out; one cycle after rd_gnt.
- flush  in  1  single-cycle pulse; drain FIFO.
- busy  out  1  high while draining.
- fifo_wr  out  1  to FIFO write_signal.
- fifo_rd  out  1  to FIFO read_signal.
- fifo_din  out  DATA_W  to FIFO data_in.
- count  out  CNT_W  occupancy 0..DEPTH, where CNT_W = clog2(DEPTH+1).
- full, empty  out  1  (count==DEPTH) and (count==0).

Behaviour:
- Reset (asynchronous, any state):
  - state=RUN, count=0, RR pointer=0 (requester 0 has highest priority).
  - All grant/valid/fifo strobes = 0; fifo_din = 0; busy = 0.
  - FIFO storage is not cleared; the FIFO shares rst_n, so its pointers reset together with this block.
- Write grant and strobes:
  - wr_gnt, fifo_wr, fifo_rd and rd_gnt are combinational from the current state, count, requests and RR pointer. There is zero latency from request to grant.
  - fifo_din = wr_data of the granted requester, or 0 when there is no grant.
  - Write allowed iff state==RUN and count<DEPTH. The grant goes to the first requesting index at or after the RR pointer, wrapping modulo NUM_REQ.
  - On a grant to requester k, the pointer becomes (k+1) mod NUM_REQ.
  - If there is no grant, the pointer holds.
  - Blocking at full is strict: no bypass, even when a read occurs in the same cycle.
- Read:
  - RUN: rd_gnt=fifo_rd=rd_req && count>0.
  - rd_valid is a registered copy of rd_gnt (1-cycle latency). It is never set by drain reads.
- Count update each cycle:
  - +1 on a write only; -1 on a read only; unchanged on both or neither.
  - Never wraps.
  - An assertion fires if count would exceed DEPTH or go below 0.
- FSM:
  - RUN -> DRAIN on flush (sampled high in RUN). Requests in the flush cycle are still served normally.
  - DRAIN:
    - busy=1.
    - wr_gnt=0 and rd_gnt=0; rd_req and wr_req are ignored.
    - fifo_rd=1 while count>0; each drain read decrements count.
    - DRAIN -> RUN in the cycle after count reaches 0. If count==0 on entry, return after one cycle.
  - flush while in DRAIN is ignored.
- Requester contract: a requester must hold wr_req and wr_data stable until it sees wr_gnt. It may drop wr_req after that.

Optional Feature:
- Macro: FIFO_ACCESS_STATS_EN.
- When defined:
  - Adds output stall_cnt (16 bits): a saturating count of cycles in which any wr_req was high but no wr_gnt was given because of full or DRAIN.
  - Adds input stat_clr: synchronous clear, which wins over increment.
  - stall_cnt resets to 0 and holds at 16'hFFFF once saturated.
- When undefined: the port, the counter and its logic are absent.

Decomposition:
- Package fifo_access_pkg:
  - state enum {RUN, DRAIN};
  - DEPTH_DEF=8;
  - clog2 function for CNT_W;
  - STALL_W=16.
- Sub-module rr_arbiter (NUM_REQ): inputs req, enable; outputs one-hot gnt, with its own pointer register. The controller supplies enable = RUN && !full.

Test Plan:
- Reset: assert rst_n=0 mid-traffic -> all outputs 0, count=0, empty=1 immediately, without waiting for a clock edge.
- Fill:
  - Requester 0 alone, wr_req held with data 0x10..0x17 -> 8 consecutive wr_gnt[0]; count reaches 8 and full=1.
  - 9th request -> wr_gnt=0 and fifo_wr=0 until a read occurs.
- Round-robin: both requesters request continuously from empty -> grants alternate 0,1,0,1; fifo_din alternates between the two data values; count increments by 1 per cycle.
- Simultaneous operations:
  - count=8, rd_req and wr_req both high -> rd_gnt=1, wr_gnt=0, count=7.
  - Next cycle, same requests -> both granted; count stays 7; rd_valid=1 one cycle after each rd_gnt.
- Empty read: count=0, rd_req=1 -> rd_gnt=0, fifo_rd=0, rd_valid stays 0.
- Flush:
  - count=5, pulse flush -> busy=1 and fifo_rd=1 for 5 cycles, count 5->0, no rd_valid and no grants; RUN in the following cycle.
  - Asserting rst_n low during the drain -> RUN, count=0.
